// File: rtl/bias_load_ctrl_if.sv
// Bias word stream between a source (master) and bias_load_ctrl (slave).
// Handshake: a word transfers on a rising clk edge where s_valid and s_ready are both 1.
interface bias_load_ctrl_if;
    logic        s_valid;
    logic [17:0] s_data;
    logic        s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/bias_load_ctrl.sv
// Bias buffer load/read controller: streams ngrp*8 bias words into the buffer, then serves group reads.
// Optional macro BIAS_LOAD_STALL_CNT_EN adds the stall_cnt output (LOAD cycles starved of s_valid).
module bias_load_ctrl #(
    parameter int DEPTH    = 128,
    parameter int ADDR_BIT = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_load,
    input  logic [ADDR_BIT:0]   num_groups,
    bias_load_ctrl_if.slave     stream,
    output logic                buf_clear,
    output logic                buf_wr_en,
    output logic [17:0]         buf_bias_in,
    output logic [ADDR_BIT-1:0] buf_addr_read,
    input  logic                rd_en,
    input  logic [ADDR_BIT-1:0] rd_group,
    output logic                bias_valid,
    output logic                rd_err,
    output logic                bias_ready,
    output logic                load_done,
`ifdef BIAS_LOAD_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic [1:0]          state_dbg
);

    localparam int CNT_W = ADDR_BIT + 4;
    localparam logic [ADDR_BIT:0] DEPTH_G = (ADDR_BIT + 1)'(DEPTH);

    // Debug encoding on state_dbg: IDLE=0, CLEAR=1, LOAD=2, READY=3.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        READY = 2'd3
    } state_t;

    state_t             state;
    logic               s_ready_r;
    logic [ADDR_BIT:0]  ngrp;
    logic [CNT_W-1:0]   word_cnt;
    logic [ADDR_BIT:0]  ngrp_next;
    logic [CNT_W-1:0]   total_words;
    logic               accept;
    logic               xfer;
    logic               last_word;
    logic               rd_ok;
    logic               rd_pend;

    assign stream.s_ready = s_ready_r;
    assign state_dbg      = state;

    assign accept      = start_load && ((state == IDLE) || (state == READY));
    assign ngrp_next   = (num_groups > DEPTH_G) ? DEPTH_G : num_groups;
    assign total_words = {ngrp, 3'b000};
    assign xfer        = stream.s_valid && s_ready_r;
    assign last_word   = xfer && ((word_cnt + CNT_W'(1)) == total_words);

    // Load sequencing. buf_wr_en/buf_bias_in trail the stream transfer by one cycle,
    // so LOAD lingers one drain cycle after the last word before entering READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_ready_r   <= 1'b0;
            buf_clear   <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_bias_in <= '0;
            bias_ready  <= 1'b0;
            load_done   <= 1'b0;
            ngrp        <= '0;
            word_cnt    <= '0;
        end else begin
            buf_clear <= 1'b0;
            load_done <= 1'b0;
            buf_wr_en <= xfer;
            if (xfer) begin
                buf_bias_in <= stream.s_data;
            end
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        state      <= CLEAR;
                        buf_clear  <= 1'b1;
                        ngrp       <= ngrp_next;
                        bias_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    word_cnt <= '0;
                    if (ngrp == '0) begin
                        state      <= READY;
                        load_done  <= 1'b1;
                        bias_ready <= 1'b1;
                    end else begin
                        state     <= LOAD;
                        s_ready_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                    if (last_word) begin
                        s_ready_r <= 1'b0;
                    end
                    if (word_cnt == total_words) begin
                        state      <= READY;
                        load_done  <= 1'b1;
                        bias_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_ok = rd_en && (state == READY) && ({1'b0, rd_group} < ngrp);

    // Read pipeline: address register, then one RAM cycle. In-flight reads are never flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend       <= 1'b0;
            bias_valid    <= 1'b0;
            rd_err        <= 1'b0;
            buf_addr_read <= '0;
        end else begin
            rd_pend    <= rd_ok;
            bias_valid <= rd_pend;
            rd_err     <= rd_en && !rd_ok;
            if (rd_ok) begin
                buf_addr_read <= rd_group;
            end
        end
    end

`ifdef BIAS_LOAD_STALL_CNT_EN
    // Counts only while LOAD is still asking for words; the drain cycle is not a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if ((state == LOAD) && s_ready_r && !stream.s_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Randomized bench for bias_load_ctrl with a queue/event-based reference model.
// Define BIAS_LOAD_STALL_CNT_EN to also check stall_cnt.
module tb_bias_load_ctrl;
    localparam int DEPTH    = 128;
    localparam int ADDR_BIT = 7;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic                start_load = 1'b0;
    logic [ADDR_BIT:0]   num_groups = '0;
    logic                rd_en      = 1'b0;
    logic [ADDR_BIT-1:0] rd_group   = '0;
    logic                buf_clear;
    logic                buf_wr_en;
    logic [17:0]         buf_bias_in;
    logic [ADDR_BIT-1:0] buf_addr_read;
    logic                bias_valid;
    logic                rd_err;
    logic                bias_ready;
    logic                load_done;
    logic [1:0]          state_dbg;
`ifdef BIAS_LOAD_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    bias_load_ctrl_if stream_if ();

    bias_load_ctrl #(.DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_load    (start_load),
        .num_groups    (num_groups),
        .stream        (stream_if),
        .buf_clear     (buf_clear),
        .buf_wr_en     (buf_wr_en),
        .buf_bias_in   (buf_bias_in),
        .buf_addr_read (buf_addr_read),
        .rd_en         (rd_en),
        .rd_group      (rd_group),
        .bias_valid    (bias_valid),
        .rd_err        (rd_err),
        .bias_ready    (bias_ready),
        .load_done     (load_done),
`ifdef BIAS_LOAD_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    // Clock and cycle index
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [17:0] exp_q[$];
    bit          exp_bv[int];
    bit          exp_err[int];
    int          exp_addr_at[int];
    int          model_addr  = 0;
    bit          model_ready = 0;
    int          model_ngrp  = 0;
    int          exp_words   = 0;
    int          xfer_cnt    = 0;
    int          wr_cnt      = 0;
    int          clear_cnt   = 0;
    int          done_cnt    = 0;
    int          last_wr_cyc = 0;
    int          start_cyc   = 0;
    bit          load_active = 0;
    bit          prev_xfer   = 0;
    logic [17:0] last_bias   = '0;
    bit          mon_xfer;
    bit          mon_sready;

    // Scoreboard: every output checked each cycle at the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_bv.delete();
            exp_err.delete();
            exp_addr_at.delete();
            prev_xfer  = 0;
            last_bias  = '0;
            model_addr = 0;
        end else begin
            mon_sready = load_active && (cyc >= start_cyc + 2) && (xfer_cnt < exp_words);
            check("s_ready", stream_if.s_ready, mon_sready);
            mon_xfer = stream_if.s_valid && stream_if.s_ready;
            check("buf_wr_en", buf_wr_en, prev_xfer);
            if (buf_wr_en) begin
                check("wr_has_word", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("buf_bias_in", buf_bias_in, exp_q.pop_front());
                wr_cnt++;
                last_wr_cyc = cyc;
                last_bias   = buf_bias_in;
            end else begin
                check("bias_in_hold", buf_bias_in, last_bias);
            end
            if (mon_xfer) begin
                exp_q.push_back(stream_if.s_data);
                xfer_cnt++;
            end
            prev_xfer = mon_xfer;
            if (buf_clear) begin
                clear_cnt++;
                check("clear_cycle", cyc, start_cyc + 1);
                check("ready_drop", bias_ready, 0);
            end
            if (load_done) begin
                done_cnt++;
                check("done_cycle", cyc, (exp_words > 0) ? last_wr_cyc + 1 : start_cyc + 2);
                check("ready_set", bias_ready, 1);
            end
            if (exp_addr_at.exists(cyc)) begin
                model_addr = exp_addr_at[cyc];
                exp_addr_at.delete(cyc);
            end
            check("buf_addr_read", buf_addr_read, model_addr);
            check("bias_valid", bias_valid, exp_bv.exists(cyc));
            if (exp_bv.exists(cyc)) exp_bv.delete(cyc);
            check("rd_err", rd_err, exp_err.exists(cyc));
            if (exp_err.exists(cyc)) exp_err.delete(cyc);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input int grp);
        bit acc;
        acc      = model_ready && (grp < model_ngrp);
        rd_en    = 1'b1;
        rd_group = ADDR_BIT'(grp);
        if (acc) begin
            exp_addr_at[cyc + 1] = grp;
            exp_bv[cyc + 2]      = 1;
        end else begin
            exp_err[cyc + 1] = 1;
        end
    endtask

    // pat: 0 continuous, 1 valid on even offsets, 2 random 3/4 valid
    task automatic do_load(input int n, input int pat, input int rd_off, input int rd_grp,
                           input bit extra_start);
        int budget;
        bit done;
        tick();
        exp_words   = ((n > DEPTH) ? DEPTH : n) * 8;
        xfer_cnt    = 0;
        wr_cnt      = 0;
        clear_cnt   = 0;
        done_cnt    = 0;
        start_cyc   = cyc;
        load_active = 1;
        start_load  = 1'b1;
        num_groups  = (ADDR_BIT + 1)'(n);
        budget      = exp_words * 4 + 40;
        done        = 0;
        for (int off = 0; off < budget && !done; off++) begin
            case (pat)
                0:       stream_if.s_valid = 1'b1;
                1:       stream_if.s_valid = (off % 2 == 0);
                default: stream_if.s_valid = ($urandom_range(0, 3) != 0);
            endcase
            stream_if.s_data = 18'($urandom);
            if (off == rd_off) issue_rd(rd_grp);
            if (off == 0) begin
                model_ready = 0;
                model_ngrp  = (n > DEPTH) ? DEPTH : n;
            end
            if (extra_start && (off == 1 || off == 5)) begin
                start_load = 1'b1;
                num_groups = (ADDR_BIT + 1)'($urandom_range(0, 9));
            end
            tick();
            start_load = 1'b0;
            rd_en      = 1'b0;
            done       = (done_cnt > 0);
        end
        stream_if.s_valid = 1'b0;
        check("load_finished", done, 1);
        check("write_count", wr_cnt, exp_words);
        check("clear_count", clear_cnt, 1);
        check("done_count", done_cnt, 1);
        check("bias_ready_level", bias_ready, 1);
        model_ready = done;
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready", stream_if.s_ready, 0);
        check("rst_buf_clear", buf_clear, 0);
        check("rst_buf_wr_en", buf_wr_en, 0);
        check("rst_buf_bias_in", buf_bias_in, 0);
        check("rst_buf_addr_read", buf_addr_read, 0);
        check("rst_bias_valid", bias_valid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_bias_ready", bias_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_state_idle", state_dbg, 0);
`ifdef BIAS_LOAD_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
    endtask

    task automatic reset_mid_load();
        int budget;
        tick();
        exp_words   = 16;
        xfer_cnt    = 0;
        wr_cnt      = 0;
        clear_cnt   = 0;
        done_cnt    = 0;
        start_cyc   = cyc;
        load_active = 1;
        start_load  = 1'b1;
        num_groups  = 2;
        stream_if.s_valid = 1'b1;
        stream_if.s_data  = 18'($urandom);
        model_ready = 0;
        model_ngrp  = 2;
        tick();
        start_load = 1'b0;
        budget = 0;
        while (xfer_cnt < 5 && budget < 50) begin
            stream_if.s_data = 18'($urandom);
            tick();
            budget++;
        end
        check("reached_word5", xfer_cnt >= 5, 1);
        #2;
        rst_n = 1'b0;
        stream_if.s_valid = 1'b0;
        #1;
        check_reset_outputs();
        load_active = 0;
        model_ready = 0;
        model_ngrp  = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", state_dbg, 0);
        check("post_rst_not_ready", bias_ready, 0);
        issue_rd(0);
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_if.s_valid = 1'b0;
        stream_if.s_data  = '0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Read before any load is rejected
        issue_rd(0);
        tick();
        rd_en = 1'b0;
        tick();

        do_load(2, 0, -1, 0, 0);
`ifdef BIAS_LOAD_STALL_CNT_EN
        check("stall_cnt_cont", stall_cnt, 0);
`endif
        do_load(1, 1, -1, 0, 0);
`ifdef BIAS_LOAD_STALL_CNT_EN
        check("stall_cnt_toggle", stall_cnt, 7);
`endif
        // Random stream, a rejected read inside LOAD, ignored start pulses in CLEAR/LOAD
        do_load(4, 2, 4, 0, 1);

        // Back-to-back reads of groups 0..3, then out of range group 4
        for (int g = 0; g < 4; g++) begin
            issue_rd(g);
            tick();
        end
        issue_rd(4);
        tick();
        rd_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) issue_rd($urandom_range(0, 7));
            else rd_en = 1'b0;
            tick();
        end
        rd_en = 1'b0;
        repeat (3) tick();

        // Read in flight while the next load is accepted
        do_load(3, 0, 0, 2, 0);
        do_load(200, 2, -1, 0, 0);
        do_load(0, 0, -1, 0, 0);
        issue_rd(0);
        tick();
        rd_en = 1'b0;
        tick();

        reset_mid_load();
        do_load(2, 2, -1, 0, 0);

        for (int k = 0; k < 4; k++) begin
            do_load($urandom_range(0, 6), $urandom_range(0, 2), -1, 0, 0);
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 2) != 0) issue_rd($urandom_range(0, 7));
                else rd_en = 1'b0;
                tick();
            end
            rd_en = 1'b0;
            repeat (3) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bias_load_ctrl.md
BIAS_LOAD_CTRL -- requirements
Module: bias_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128: bias entries per channel RAM (8-channel groups storable).
REQ-002 SHALL have parameter ADDR_BIT, default 7: RAM address width; DEPTH <= 2^ADDR_BIT.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_load, input, 1: load request pulse.
REQ-006 SHALL have port num_groups, input, ADDR_BIT+1: groups of 8 bias words to load; sampled on accepted start_load.
REQ-007 SHALL have port s_valid, input, 1: bias stream word valid.
REQ-008 SHALL have port s_data, input, 18: bias stream word.
REQ-009 SHALL have port s_ready, output, 1: stream ready; a word transfers when s_valid and s_ready are both 1.
REQ-010 SHALL have port buf_clear, output, 1: pointer clear to the bias buffer.
REQ-011 SHALL have port buf_wr_en, output, 1: bias buffer write enable.
REQ-012 SHALL have port buf_bias_in, output, 18: bias buffer write data.
REQ-013 SHALL have port buf_addr_read, output, ADDR_BIT: bias buffer read address.
REQ-014 SHALL have port rd_en, input, 1: compute-side request for one group.
REQ-015 SHALL have port rd_group, input, ADDR_BIT: requested group index.
REQ-016 SHALL have port bias_valid, output, 1: the 8 bias outputs of the buffer are valid this cycle.
REQ-017 SHALL have port rd_err, output, 1: one-cycle pulse on a rejected read.
REQ-018 SHALL have port bias_ready, output, 1: level; a complete bias set is loaded.
REQ-019 SHALL have port load_done, output, 1: one-cycle pulse when a load completes.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, LOAD and READY.
REQ-021 SHALL accept start_load only in IDLE or READY and then go to CLEAR; start_load in CLEAR or LOAD SHALL be ignored.
REQ-022 SHALL, on acceptance, latch ngrp = min(num_groups, DEPTH) and deassert bias_ready in the next cycle.
REQ-023 SHALL drive buf_clear=1 for exactly the one cycle spent in CLEAR, then enter LOAD; if ngrp=0, go to READY instead.
REQ-024 SHALL drive s_ready=1 only in LOAD, and SHALL count transferred words with a counter of width ADDR_BIT+4.
REQ-025 SHALL register each transferred word: buf_wr_en=1 and buf_bias_in=s_data exactly 1 cycle after the transfer; otherwise buf_wr_en=0 and buf_bias_in holds its value.
REQ-026 SHALL drop s_ready in the cycle after the word ngrp*8 transfers; stream stalls (s_valid=0) SHALL insert no writes.
REQ-027 SHALL enter READY in the cycle after the final buf_wr_en, pulse load_done for 1 cycle, and set bias_ready=1 until the next accepted start_load.
REQ-028 SHALL treat rd_en in READY with rd_group < ngrp as accepted: buf_addr_read=rd_group registered 1 cycle later, bias_valid=1 2 cycles after rd_en (1 cycle address register, 1 cycle RAM read).
REQ-029 SHALL accept rd_en back-to-back, one request per cycle, fully pipelined.
REQ-030 SHALL reject rd_en outside READY, or with rd_group >= ngrp, with an rd_err pulse 1 cycle later, no bias_valid, and buf_addr_read unchanged.
REQ-031 SHALL not cancel read requests already in flight when start_load is accepted; those bias_valid pulses still occur.

Reset
REQ-032 SHALL, while rst_n=0, hold state=IDLE, with s_ready, buf_clear, buf_wr_en, bias_valid, rd_err, bias_ready and load_done all 0, buf_bias_in=0, buf_addr_read=0, ngrp=0, and word counter 0.
REQ-033 SHALL abandon a load when reset asserts mid-load; after release the block SHALL wait in IDLE, and the next load SHALL begin with CLEAR.

Configuration
REQ-034 SHALL, with macro BIAS_LOAD_STALL_CNT_EN defined, add output stall_cnt[15:0]: cycles in LOAD with s_valid=0, cleared on entering CLEAR and on reset, saturating at 16'hFFFF.
REQ-035 SHALL, without BIAS_LOAD_STALL_CNT_EN, have no stall_cnt port and no counter logic.

Verification
REQ-036 SHALL cover: num_groups=2 with continuous s_valid -> buf_clear for 1 cycle, 16 buf_wr_en cycles with data echoed 1 cycle late, s_ready low after 16 words, load_done 1 cycle after the last write.
REQ-037 SHALL cover: num_groups=1, s_valid toggled every other cycle -> exactly 8 writes; with the macro, stall_cnt=7.
REQ-038 SHALL cover: after load of 4 groups, rd_en for groups 0,1,2,3 in consecutive cycles -> buf_addr_read 0..3 starting 1 cycle later, bias_valid high 4 cycles starting 2 cycles after the first rd_en.
REQ-039 SHALL cover: rd_group=4 with ngrp=4, and rd_en in LOAD -> rd_err pulse each, no bias_valid.
REQ-040 SHALL cover: num_groups=200, DEPTH=128 -> exactly 1024 writes; num_groups=0 -> load_done with no writes.
REQ-041 SHALL cover: rst_n low after word 5 of a load -> all outputs 0 asynchronously; the next start_load gives a full CLEAR and reload.
